// File: rtl/dispatch_ctrl.sv
// Instruction dispatcher: decodes prefix opcodes, selects EU/BIU/FCU,
// resolves branches, traps on illegal opcode/condition or unit timeout.
// Ports: clk, rst; ir_valid/ir_ready/ir/flags in; unit_done[2:0] in;
// cs/sel_eu/sel_biu/sel_fcu out; done/br_skip/busy/err/err_code out;
// err_clr in.
module dispatch_ctrl #(
  parameter int IR_W     = 32,
  parameter int OPC_MSB  = 21,
  parameter int COND_LSB = 15,
  parameter int FLAG_W   = 2,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic [IR_W-1:0]   ir,
  input  logic [FLAG_W-1:0] flags,
  input  logic [2:0]        unit_done,
  output logic [2:0]        cs,
  output logic [1:0]        sel_eu,
  output logic [1:0]        sel_biu,
  output logic              sel_fcu,
  output logic              done,
  output logic              br_skip,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_DISPATCH,
    S_COMPLETE,
    S_TRAP
  } state_e;

  state_e           state_q;
  logic [5:0]       opc_q;
  logic [2:0]       cond_q;
  logic [1:0]       flg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       cs_q;
  logic [1:0]       sel_eu_q;
  logic [1:0]       sel_biu_q;
  logic             sel_fcu_q;
  logic             done_q;
  logic             skip_q;
  logic             busy_q;
  logic             err_q;
  logic [1:0]       code_q;

  logic [2:0] dec_cs;
  logic [1:0] dec_sel;
  logic       dec_ill;
  logic       br_take;
  logic       cond_ill;

  // Only the opcode/condition fields and two flags are consumed.
  logic unused_in;
  assign unused_in = ^{ir, flags};

  // Prefix code: count of leading ones picks the class.
  always_comb begin
    dec_cs  = '0;
    dec_sel = '0;
    dec_ill = 1'b0;
    casez (opc_q)
      6'b0?????: dec_cs = 3'b001;
      6'b10????: dec_cs = 3'b010;
      6'b110???: begin
        dec_cs  = 3'b010;
        dec_sel = 2'd1;
      end
      6'b1110??: dec_cs = 3'b100;
      6'b11110?: begin
        dec_cs  = 3'b001;
        dec_sel = 2'd1;
      end
      6'b111110: begin
        dec_cs  = 3'b001;
        dec_sel = 2'd2;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    br_take  = 1'b0;
    cond_ill = 1'b0;
    case (cond_q)
      3'd0:    br_take  = 1'b1;
      3'd1:    br_take  = ~flg_q[0];
      3'd2:    br_take  = flg_q[0];
      3'd3:    br_take  = ~flg_q[1];
      3'd4:    br_take  = flg_q[1];
      default: cond_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      cond_q    <= '0;
      flg_q     <= '0;
      cnt_q     <= '0;
      cs_q      <= '0;
      sel_eu_q  <= '0;
      sel_biu_q <= '0;
      sel_fcu_q <= 1'b0;
      done_q    <= 1'b0;
      skip_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      done_q <= 1'b0;
      skip_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ir_valid) begin
            opc_q   <= ir[OPC_MSB -: 6];
            cond_q  <= ir[COND_LSB +: 3];
            flg_q   <= flags[1:0];
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_ill) begin
            err_q   <= 1'b1;
            code_q  <= 2'd1;
            state_q <= S_TRAP;
          end else if (dec_cs[2] && cond_ill) begin
            err_q   <= 1'b1;
            code_q  <= 2'd3;
            state_q <= S_TRAP;
          end else if (dec_cs[2] && !br_take) begin
            done_q  <= 1'b1;
            skip_q  <= 1'b1;
            state_q <= S_COMPLETE;
          end else begin
            cs_q      <= dec_cs;
            sel_eu_q  <= dec_cs[0] ? dec_sel : 2'd0;
            sel_biu_q <= dec_cs[1] ? dec_sel : 2'd0;
            sel_fcu_q <= dec_cs[2] & dec_sel[0];
            cnt_q     <= '0;
            state_q   <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          // Completion is checked first so it wins over timeout.
          if (|(unit_done & cs_q)) begin
            cs_q      <= '0;
            sel_eu_q  <= '0;
            sel_biu_q <= '0;
            sel_fcu_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_COMPLETE;
          end else if (cnt_q == TO_LAST) begin
            cs_q      <= '0;
            sel_eu_q  <= '0;
            sel_biu_q <= '0;
            sel_fcu_q <= 1'b0;
            err_q     <= 1'b1;
            code_q    <= 2'd2;
            state_q   <= S_TRAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_COMPLETE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_TRAP: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ir_ready = (state_q == S_IDLE);
  assign cs       = cs_q;
  assign sel_eu   = sel_eu_q;
  assign sel_biu  = sel_biu_q;
  assign sel_fcu  = sel_fcu_q;
  assign done     = done_q;
  assign br_skip  = skip_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule
